// File: rtl/spi_slave_shift.sv
// SPI slave shift engine: oversamples the SPI pads on clk_shift, receives a
// len-bit character into p_out and returns the latched tx_buf on s_out.
// Back-to-back characters are supported while ss_n stays low.
module spi_slave_shift #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_shift,
    input  logic        rst,
    input  logic        ss_n,
    input  logic        s_clk,
    input  logic        s_in,
    output logic        s_out,
    output logic        s_oe,
    input  logic [4:0]  len,
    input  logic        lsb,
    input  logic        rx_negedge,
    input  logic        tx_negedge,
    input  logic        latch,
    input  logic [3:0]  byte_sel,
    input  logic [31:0] p_in,
    output logic [31:0] p_out,
    output logic        tip,
    output logic        done,
    output logic        abort
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, sin_sync_q;
    logic                   sclk_hist_q, ss_hist_q;
    logic                   sclk_s, ss_s, sin_s;
    logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic                   sample_edge, drive_edge;

    logic [0:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] tx_buf_q, tx_buf_d;
    logic [31:0] shift_tx_q, shift_tx_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] p_out_q, p_out_d;
    logic        s_out_q, s_out_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;

    logic [5:0]  n_len;
    logic [4:0]  first_idx, bit_idx;

    // Pad synchronizers plus one history flop for edge detection on s_clk/ss_n
    always_ff @(posedge clk_shift) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            sin_sync_q  <= '0;
            sclk_hist_q <= 1'b0;
            ss_hist_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], s_clk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
            sin_sync_q  <= {sin_sync_q[SYNC_STAGES-2:0], s_in};
            sclk_hist_q <= sclk_s;
            ss_hist_q   <= ss_s;
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign sin_s       = sin_sync_q[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_hist_q;
    assign sclk_fall   = ~sclk_s & sclk_hist_q;
    assign ss_fall     = ~ss_s & ss_hist_q;
    assign ss_rise     = ss_s & ~ss_hist_q;
    assign sample_edge = rx_negedge ? sclk_fall : sclk_rise;
    assign drive_edge  = tx_negedge ? sclk_fall : sclk_rise;

    // Indices are taken mod 32, so len==0 naturally maps to a 32-bit character
    assign n_len     = (len == 5'd0) ? 6'd32 : {1'b0, len};
    assign first_idx = lsb ? 5'd0 : len - 5'd1;
    assign bit_idx   = lsb ? len - cnt_q[4:0] : cnt_q[4:0] - 5'd1;

    // Next-state: tx buffer writes, character framing, shift and reload
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_buf_d   = tx_buf_q;
        shift_tx_d = shift_tx_q;
        rx_d       = rx_q;
        p_out_d    = p_out_q;
        s_out_d    = s_out_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;

        for (int k = 0; k < 4; k++) begin
            if (latch && byte_sel[k]) tx_buf_d[k*8 +: 8] = p_in[k*8 +: 8];
        end

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d    = ACTIVE;
                    cnt_d      = n_len;
                    shift_tx_d = tx_buf_d;
                    rx_d       = '0;
                    s_out_d    = tx_buf_d[first_idx];
                end
            end
            default: begin
                if (ss_rise) begin
                    // Deselect wins over any concurrent sample edge
                    state_d = IDLE;
                    if (cnt_q == 6'd0) begin
                        done_d  = 1'b1;
                        p_out_d = rx_q;
                    end else if (cnt_q != n_len) begin
                        abort_d = 1'b1;
                    end
                end else if (cnt_q == 6'd0) begin
                    // Character complete: publish and reload for the next one
                    done_d     = 1'b1;
                    p_out_d    = rx_q;
                    cnt_d      = n_len;
                    shift_tx_d = tx_buf_d;
                    rx_d       = '0;
                    s_out_d    = tx_buf_d[first_idx];
                end else begin
                    if (sample_edge) begin
                        rx_d[bit_idx] = sin_s;
                        cnt_d         = cnt_q - 6'd1;
                    end
                    // cnt==N means no sample yet: keep the first bit stable
                    if (drive_edge && cnt_q != n_len) begin
                        s_out_d = shift_tx_q[bit_idx];
                    end
                end
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk_shift) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_buf_q   <= '0;
            shift_tx_q <= '0;
            rx_q       <= '0;
            p_out_q    <= '0;
            s_out_q    <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_buf_q   <= tx_buf_d;
            shift_tx_q <= shift_tx_d;
            rx_q       <= rx_d;
            p_out_q    <= p_out_d;
            s_out_q    <= s_out_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign s_out = s_out_q;
    assign s_oe  = (state_q == ACTIVE);
    assign tip   = (state_q == ACTIVE);
    assign p_out = p_out_q;
    assign done  = done_q;
    assign abort = abort_q;

endmodule

// File: tb/tb_spi_slave_shift.sv
// Bench for spi_slave_shift: a behavioural SPI master drives the pads, the
// expected data comes from plain word/mask arithmetic on the character.
module tb_spi_slave_shift;

    localparam int SYNC = 2;
    localparam int HALF = 60;   // s_clk half period: 6 clk_shift cycles

    logic        clk_shift = 1'b0;
    logic        rst = 1'b1;
    logic        ss_n = 1'b1, s_clk = 1'b0, s_in = 1'b0;
    logic        s_out, s_oe, tip, done, abort;
    logic [4:0]  len = 5'd8;
    logic        lsb = 1'b0, rx_negedge = 1'b0, tx_negedge = 1'b1, latch = 1'b0;
    logic [3:0]  byte_sel = 4'd0;
    logic [31:0] p_in = '0, p_out;

    spi_slave_shift #(.SYNC_STAGES(SYNC)) dut (
        .clk_shift(clk_shift), .rst(rst), .ss_n(ss_n), .s_clk(s_clk), .s_in(s_in),
        .s_out(s_out), .s_oe(s_oe), .len(len), .lsb(lsb), .rx_negedge(rx_negedge),
        .tx_negedge(tx_negedge), .latch(latch), .byte_sel(byte_sel), .p_in(p_in),
        .p_out(p_out), .tip(tip), .done(done), .abort(abort)
    );

    always #5 clk_shift = ~clk_shift;

    int nvec = 0, nbad = 0;
    int done_cnt = 0, abort_cnt = 0, both_cnt = 0;
    logic [31:0] done_q[$];

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk_shift) begin
        if (done) begin
            done_cnt++;
            done_q.push_back(p_out);
        end
        if (abort) abort_cnt++;
        if (done && abort) both_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [4:0]  len;
        logic        lsb;
        logic        modeb;
        logic [31:0] tx;
        logic [31:0] mosi;
        logic [31:0] exp_p;
        logic [31:0] exp_miso;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int nbits(input logic [4:0] l);
        return (l == 5'd0) ? 32 : int'(l);
    endfunction

    function automatic logic [31:0] mask(input int n);
        return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    task automatic load_tx(input logic [31:0] d, input logic [3:0] sel);
        @(negedge clk_shift);
        latch = 1'b1; p_in = d; byte_sel = sel;
        @(negedge clk_shift);
        latch = 1'b0; byte_sel = 4'd0;
    endtask

    // modeb=0: slave samples on rise / drives on fall; modeb=1: the reverse
    task automatic set_cfg(input logic [4:0] l, input logic lb, input logic mb);
        len = l; lsb = lb; rx_negedge = mb; tx_negedge = ~mb;
    endtask

    // Master shifts n bits of mosi; miso bits collected into word positions
    task automatic xfer(input int n, input logic lb, input logic mb,
                        input logic [31:0] mosi, output logic [31:0] miso);
        int idx;
        miso = '0;
        for (int i = 0; i < n; i++) begin
            idx = lb ? i : n - 1 - i;
            if (!mb) begin
                s_in = mosi[idx]; #HALF;
                miso[idx] = s_out; s_clk = 1'b1; #HALF;
                s_clk = 1'b0;
            end else begin
                s_clk = 1'b1; s_in = mosi[idx]; #HALF;
                miso[idx] = s_out; s_clk = 1'b0; #HALF;
            end
        end
    endtask

    task automatic one_char(input string name, input logic [4:0] l, input logic lb,
                            input logic mb, input logic [31:0] mosi,
                            input logic [31:0] exp_p, input logic [31:0] exp_miso);
        int d0, a0;
        logic [31:0] miso;
        d0 = done_cnt; a0 = abort_cnt;
        set_cfg(l, lb, mb);
        ss_n = 1'b0; #HALF;
        chk({name, ".tip"}, {31'd0, tip}, 32'd1);
        chk({name, ".s_oe"}, {31'd0, s_oe}, 32'd1);
        xfer(nbits(l), lb, mb, mosi, miso);
        #HALF; ss_n = 1'b1; #100;
        chk({name, ".done_pulses"}, done_cnt - d0, 1);
        chk({name, ".abort_pulses"}, abort_cnt - a0, 0);
        chk({name, ".p_out"}, p_out, exp_p);
        chk({name, ".miso"}, miso, exp_miso);
        chk({name, ".s_oe_idle"}, {31'd0, s_oe}, 32'd0);
    endtask

    initial begin
        logic [31:0] m1, m2, tx, mosi;
        logic [4:0]  l;
        logic        lb, mb;
        int d0, a0, n;

        tbl[0] = '{5'd8,  1'b0, 1'b0, 32'h0000_00A5, 32'h0000_003C, 32'h0000_003C, 32'h0000_00A5};
        tbl[1] = '{5'd0,  1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF};
        tbl[2] = '{5'd5,  1'b0, 1'b1, 32'h0000_00F3, 32'h0000_003A, 32'h0000_001A, 32'h0000_0013};
        tbl[3] = '{5'd16, 1'b1, 1'b1, 32'h1234_BEEF, 32'hFFFF_0F0F, 32'h0000_0F0F, 32'h0000_BEEF};

        // Reset state
        repeat (3) @(negedge clk_shift);
        chk("rst.s_out", {31'd0, s_out}, 32'd0);
        chk("rst.s_oe", {31'd0, s_oe}, 32'd0);
        chk("rst.tip", {31'd0, tip}, 32'd0);
        chk("rst.p_out", p_out, 32'd0);
        chk("rst.pulses", {30'd0, done, abort}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk_shift);

        // Directed table
        for (int i = 0; i < 4; i++) begin
            load_tx(tbl[i].tx, 4'b1111);
            one_char($sformatf("tbl%0d", i), tbl[i].len, tbl[i].lsb, tbl[i].modeb,
                     tbl[i].mosi, tbl[i].exp_p, tbl[i].exp_miso);
        end

        // Back-to-back 4-bit characters with a tx_buf update mid-character
        load_tx(32'h0000_000C, 4'b1111);
        set_cfg(5'd4, 1'b0, 1'b0);
        done_q.delete();
        d0 = done_cnt; a0 = abort_cnt;
        ss_n = 1'b0; #HALF;
        fork
            begin
                xfer(4, 1'b0, 1'b0, 32'h9, m1);
                xfer(4, 1'b0, 1'b0, 32'h6, m2);
            end
            begin
                #(3*HALF);
                load_tx(32'h0000_0003, 4'b0001);
            end
        join
        #HALF; ss_n = 1'b1; #100;
        chk("b2b.done_pulses", done_cnt - d0, 2);
        chk("b2b.abort_pulses", abort_cnt - a0, 0);
        chk("b2b.p_out0", (done_q.size() > 0) ? done_q[0] : 32'hXXXX_XXXX, 32'h9);
        chk("b2b.p_out1", (done_q.size() > 1) ? done_q[1] : 32'hXXXX_XXXX, 32'h6);
        chk("b2b.miso0", m1, 32'hC);
        chk("b2b.miso1", m2, 32'h3);

        // Abort after 3 of 8 bits
        load_tx(32'h0000_00FF, 4'b1111);
        set_cfg(5'd8, 1'b0, 1'b0);
        d0 = done_cnt; a0 = abort_cnt;
        ss_n = 1'b0; #HALF;
        xfer(3, 1'b0, 1'b0, 32'h5, m1);
        ss_n = 1'b1;
        repeat (SYNC + 2) @(posedge clk_shift);
        #1;
        chk("abort.s_oe", {31'd0, s_oe}, 32'd0);
        chk("abort.tip", {31'd0, tip}, 32'd0);
        #100;
        chk("abort.abort_pulses", abort_cnt - a0, 1);
        chk("abort.done_pulses", done_cnt - d0, 0);
        chk("abort.p_out_kept", p_out, 32'h6);

        // Partial byte write into tx_buf
        load_tx(32'h1122_3344, 4'b1111);
        load_tx(32'hAABB_CCDD, 4'b0101);
        one_char("bytesel", 5'd0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h11BB_33DD);

        // Reset in the middle of a character
        load_tx(32'h0000_00FF, 4'b1111);
        set_cfg(5'd8, 1'b0, 1'b0);
        d0 = done_cnt; a0 = abort_cnt;
        ss_n = 1'b0; #HALF;
        xfer(5, 1'b0, 1'b0, 32'h1B, m1);
        @(negedge clk_shift); rst = 1'b1;
        @(negedge clk_shift); rst = 1'b0; ss_n = 1'b1;
        chk("midrst.tip", {31'd0, tip}, 32'd0);
        chk("midrst.s_oe", {31'd0, s_oe}, 32'd0);
        chk("midrst.s_out", {31'd0, s_out}, 32'd0);
        chk("midrst.p_out", p_out, 32'd0);
        #100;
        chk("midrst.done_pulses", done_cnt - d0, 0);
        chk("midrst.abort_pulses", abort_cnt - a0, 0);
        one_char("postrst_txbuf", 5'd8, 1'b0, 1'b0, 32'h77, 32'h77, 32'h0);

        // Randomized characters against the word/mask model
        for (int i = 0; i < 25; i++) begin
            l = 5'($urandom_range(0, 31));
            lb = 1'($urandom_range(0, 1));
            mb = 1'($urandom_range(0, 1));
            tx = $urandom;
            mosi = $urandom;
            n = nbits(l);
            load_tx(tx, 4'b1111);
            one_char($sformatf("rnd%0d", i), l, lb, mb, mosi, mosi & mask(n), tx & mask(n));
        end

        chk("one_pulse_per_cycle", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
